inv_sub_bytes_iter: RTL
=======================

// Module: inv_sub_bytes_iter
// PURPOSE
//   Iterative InvSubBytes stage of the AES decryption round datapath.
//   - Accepts a 128-bit state from InvShiftRows.
//   - Substitutes all 16 bytes through LANES instances of inv_s_box, LANES bytes per cycle.
//   - Presents the result to AddRoundKey over a valid/ready handshake.
//   - Trades latency for area: LANES=16 is fully parallel, LANES=1 uses one S-box.
// PARAMETERS
//   LANES  4  inv_s_box instances, i.e. bytes substituted per cycle; legal values 1,2,4,8,16
//   PASSES derived, 16/LANES; substitution cycles per block (not user-settable)
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous, active-high reset
//   in_valid   in   1    upstream state is valid
//   in_ready   out  1    block can accept a state this cycle
//   in_state   in   128  state in; byte 0 = [127:120] ... byte 15 = [7:0]
//   out_valid  out  1    out_state holds a finished InvSubBytes result
//   out_ready  in   1    downstream accepts out_state
//   out_state  out  128  substituted state, same byte ordering as in_state
//   busy       out  1    high in SUB or DONE
// BEHAVIOUR
//   Reset (rst=1 at a clock edge):
//   - FSM goes to IDLE; pass counter cnt=0.
//   - State buffer = 128'h0, so out_state = 0; out_valid = 0.
//   - in_ready is forced 0 during any cycle in which rst is high.
//   - Reset mid-operation discards the block in flight; nothing is emitted for it.
//   FSM states:
//   - IDLE: in_ready=1.
//     - On in_valid&&in_ready: buffer <= in_state, cnt <= 0, go to SUB.
//   - SUB: in_ready=0, out_valid=0.
//     - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 are replaced in place by inv_s_box(byte).
//     - cnt increments each cycle.
//     - When cnt==PASSES-1: cnt <= 0, go to DONE.
//   - DONE: out_valid=1, out_state = buffer.
//     - On out_ready: go to IDLE.
//     - Otherwise hold; out_state is stable and in_ready stays 0.
//   Handshake:
//   - Transfer occurs only when valid&&ready are both high at a rising edge.
//   - out_valid never drops without out_ready.
//   - Only one block is in flight at a time; a new block is accepted no earlier than the cycle after the DONE handshake.
//   - in_state is sampled only at the accept edge; later changes are ignored.
//   Latency:
//   - Accept at edge N gives out_valid high after edge N+PASSES.
//   - LANES=4: 4 cycles. LANES=16: 1 cycle. LANES=1: 16 cycles.
//   - Throughput: one block per PASSES+2 cycles with out_ready tied high.
//   Data path:
//   - Byte-wise substitution; no carries, no width growth.
//   - S-box lookup is combinational from the buffer, registered back into the buffer.
//   - Lane select is a mux on cnt; cnt width is clog2(PASSES), minimum 1 bit.
//   Boundary conditions:
//   - in_valid while busy: ignored; upstream must hold until in_ready.
//   - out_ready high while not out_valid: no effect.
//   - Simultaneous rst and handshake: rst wins, the transfer is dropped.
//   - Illegal LANES (not a divisor of 16): $error at elaboration.
// TESTING
//   - FIPS-197 row vector, LANES=4: in_state=128'h637c777bf26b6fc53001672bfed7ab76, out_ready=1
//     -> out_valid high 4 cycles after accept, out_state=128'h000102030405060708090a0b0c0d0e0f.
//   - All-zero input: in_state=0 -> out_state=128'h52525252525252525252525252525252.
//     Repeat with LANES=1 (latency 16) and LANES=16 (latency 1).
//   - Byte order: in_state=128'h16{15{8'h63}} -> out_state=128'hff{15{8'h00}}; proves byte 0 is [127:120].
//   - Back-pressure: out_ready=0 for 6 cycles in DONE -> out_state/out_valid stable, in_ready=0.
//     out_ready=1 -> next cycle IDLE, in_ready=1.
//   - Reset mid-SUB: assert rst at cnt=2 -> next cycle out_valid=0, out_state=0, busy=0.
//     A fresh block after reset yields the correct result.
//   - Back-to-back: in_valid held high with 3 random states, compared against a software InvSubBytes model
//     -> all 3 emitted in order, one per PASSES+2 cycles, none lost or duplicated.

Source files
------------

// File: rtl/inv_sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_iter : iterative AES InvSubBytes, LANES bytes per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inv_s_box (
    input  logic [7:0] value,
    output logic [7:0] result
);
    // Row r of the FIPS-197 inverse S-box occupies one 32-digit group below.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    logic [10:0] bit_idx;

    assign bit_idx = 11'd2047 - {value, 3'b000};
    assign result  = INV_SBOX[bit_idx -: 8];
endmodule

module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int PASSES = 16 / LANES;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    if ((LANES < 1) || (LANES > 16) || ((16 % LANES) != 0)) begin : g_bad_lanes
        $error("inv_sub_bytes_iter: LANES must divide 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [7:0]      buf_q    [16];
    logic [7:0]      lane_in  [LANES];
    logic [7:0]      lane_out [LANES];
    logic [4:0]      base;
    logic            accept;
    logic            last_pass;

    assign base      = 5'(cnt) * 5'(LANES);
    assign accept    = in_valid && in_ready;
    assign last_pass = (cnt == CW'(PASSES - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = buf_q[4'(base + 5'(l))];
        inv_s_box u_sbox (
            .value  (lane_in[l]),
            .result (lane_out[l])
        );
    end

    for (genvar b = 0; b < 16; b++) begin : g_out
        assign out_state[127-8*b -: 8] = buf_q[b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    next_state = SUB;
                end
            end
            SUB: begin
                busy = 1'b1;
                if (last_pass) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Substituted lanes are written back in place, so the buffer doubles as the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            for (int b = 0; b < 16; b++) begin
                buf_q[b] <= 8'h00;
            end
        end else if (accept) begin
            cnt <= '0;
            for (int b = 0; b < 16; b++) begin
                buf_q[b] <= in_state[127-8*b -: 8];
            end
        end else if (state == SUB) begin
            for (int l = 0; l < LANES; l++) begin
                buf_q[4'(base + 5'(l))] <= lane_out[l];
            end
            cnt <= last_pass ? '0 : cnt + 1'b1;
        end
    end
endmodule

`default_nettype wire
